// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline control bus: stage register/enable inputs to the hazard controller and its steering outputs.
// master = pipeline side driving stage info; slave = controller.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 4
);
  logic [REG_AW-1:0] id_src1;
  logic [REG_AW-1:0] id_src2;
  logic              id_src1_vld;
  logic              id_two_src;
  logic [REG_AW-1:0] exe_dest;
  logic              exe_wb_en;
  logic              exe_mem_r_en;
  logic [REG_AW-1:0] mem_dest;
  logic              mem_wb_en;
  logic [REG_AW-1:0] wb_dest;
  logic              wb_wb_en;
  logic [REG_AW-1:0] exe_src1;
  logic [REG_AW-1:0] exe_src2;
  logic              mem_req;
  logic              br_taken_in;
  logic [31:0]       br_addr_in;

  logic              freeze;
  logic              flush;
  logic              branch_taken;
  logic [31:0]       branch_addr;
  logic              stall_all;
  logic              mem_ready;
  logic [1:0]        fwd_sel1;
  logic [1:0]        fwd_sel2;

  modport master (
    output id_src1, id_src2, id_src1_vld, id_two_src,
           exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, wb_dest, wb_wb_en,
           exe_src1, exe_src2, mem_req, br_taken_in, br_addr_in,
    input  freeze, flush, branch_taken, branch_addr,
           stall_all, mem_ready, fwd_sel1, fwd_sel2
  );

  modport slave (
    input  id_src1, id_src2, id_src1_vld, id_two_src,
           exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, wb_dest, wb_wb_en,
           exe_src1, exe_src2, mem_req, br_taken_in, br_addr_in,
    output freeze, flush, branch_taken, branch_addr,
           stall_all, mem_ready, fwd_sel1, fwd_sel2
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Freeze/flush/redirect and MEM_WAIT-cycle global stall; all outputs combinational except mem_ready (state decode).
// No backpressure input: stall_all holds the whole pipe; FORWARDING_EN adds EXE forwarding and load-use-only freeze.
module pipe_hazard_ctrl #(
  parameter int MEM_WAIT = 4,
  parameter int REG_AW   = 4
) (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(MEM_WAIT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       stall;
  logic       hz;
  logic [1:0] sel1;
  logic [1:0] sel2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt holds the number of stall cycles already spent on this access.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_req) begin
          stall     = 1'b1;
          cnt_nxt   = 4'd1;
          state_nxt = (MEM_WAIT == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == LAST_CNT) begin
          state_nxt = DONE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  logic [REG_AW-1:0] src1;
  logic [REG_AW-1:0] src2;
  assign src1 = bus.id_src1;
  assign src2 = bus.id_src2;

`ifdef FORWARDING_EN
  // With forwarding only a load in EXE cannot supply its result in time.
  assign hz = bus.exe_mem_r_en & bus.exe_wb_en &
              ((bus.id_src1_vld & (src1 == bus.exe_dest)) |
               (bus.id_two_src  & (src2 == bus.exe_dest)));

  always_comb begin
    sel1 = 2'b00;
    sel2 = 2'b00;
    if (bus.mem_wb_en && bus.exe_src1 == bus.mem_dest)
      sel1 = 2'b01;
    else if (bus.wb_wb_en && bus.exe_src1 == bus.wb_dest)
      sel1 = 2'b10;
    if (bus.mem_wb_en && bus.exe_src2 == bus.mem_dest)
      sel2 = 2'b01;
    else if (bus.wb_wb_en && bus.exe_src2 == bus.wb_dest)
      sel2 = 2'b10;
  end
`else
  assign hz = (bus.id_src1_vld &
               ((bus.exe_wb_en & (src1 == bus.exe_dest)) |
                (bus.mem_wb_en & (src1 == bus.mem_dest)))) |
              (bus.id_two_src &
               ((bus.exe_wb_en & (src2 == bus.exe_dest)) |
                (bus.mem_wb_en & (src2 == bus.mem_dest))));

  assign sel1 = 2'b00;
  assign sel2 = 2'b00;

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{bus.exe_mem_r_en, bus.exe_src1, bus.exe_src2,
                               bus.wb_dest, bus.wb_wb_en};
`endif

  // Stall outranks a branch (EXE is held, so the branch waits); a branch outranks hz.
  assign bus.stall_all    = rst & stall;
  assign bus.branch_taken = rst & ~stall & bus.br_taken_in;
  assign bus.flush        = rst & ~stall & bus.br_taken_in;
  assign bus.freeze       = rst & ~stall & ~bus.br_taken_in & hz;
  assign bus.branch_addr  = rst ? bus.br_addr_in : 32'd0;
  assign bus.mem_ready    = rst & (state == DONE);
  assign bus.fwd_sel1     = rst ? sel1 : 2'b00;
  assign bus.fwd_sel2     = rst ? sel2 : 2'b00;

endmodule
